i2s_rx_deser: RTL and testbench



---
 rtl/i2s_rx_deser.sv | 153 +++++++++++++++
 tb/tb_i2s_rx_deser.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_deser.sv
// rtl/i2s_rx_deser.sv - I2S receiver turning oversampled BCK/LRCK/DATA into stereo samples
// Define I2S_RX_ERR_CNT_EN to add the saturating err_count output.
module i2s_rx_deser #(
  parameter int SAMPLE_BITS    = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i2s_bck,
  input  logic                   i2s_lrck,
  input  logic                   i2s_data,
  output logic [SAMPLE_BITS-1:0] left,
  output logic [SAMPLE_BITS-1:0] right,
  output logic                   sample_valid,
  output logic                   frame_err,
`ifdef I2S_RX_ERR_CNT_EN
  output logic [7:0]             err_count,
`endif
  output logic                   locked
);

  localparam int CW = $clog2(SAMPLE_BITS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] FULL  = CW'(SAMPLE_BITS);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TTRIG = TW'(TIMEOUT_CYCLES - 2);

  logic [SYNC_STAGES-1:0] bck_sync_q, lrck_sync_q, data_sync_q;
  logic                   bck_prev_q, lrck_prev_q;
  logic                   bck_s, lrck_s, data_s, bck_rise;

  logic [SAMPLE_BITS-1:0] shift_q, shift_d, shift_inc;
  logic [SAMPLE_BITS-1:0] held_q, held_d;
  logic [SAMPLE_BITS-1:0] left_q, left_d, right_q, right_d;
  logic [CW-1:0]          bitcnt_q, bitcnt_d, bitcnt_inc;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic [1:0]             good_q, good_d;
  logic                   aligned_q, aligned_d, left_ok_q, left_ok_d;
  logic                   valid_q, valid_d, err_q, err_d;

  assign bck_s    = bck_sync_q[SYNC_STAGES-1];
  assign lrck_s   = lrck_sync_q[SYNC_STAGES-1];
  assign data_s   = data_sync_q[SYNC_STAGES-1];
  assign bck_rise = bck_s & ~bck_prev_q;

  // Synchronizers and LRCK history keep tracking through reset so the first
  // boundary after release is a genuine LRCK change.
  always_ff @(posedge clk) begin
    bck_sync_q  <= {bck_sync_q[SYNC_STAGES-2:0], i2s_bck};
    lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], i2s_lrck};
    data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], i2s_data};
    bck_prev_q  <= bck_s;
    if (bck_rise) lrck_prev_q <= lrck_s;
  end

  always_comb begin
    shift_d    = shift_q;
    bitcnt_d   = bitcnt_q;
    shift_inc  = shift_q;
    bitcnt_inc = bitcnt_q;
    held_d     = held_q;
    left_d     = left_q;
    right_d    = right_q;
    aligned_d  = aligned_q;
    left_ok_d  = left_ok_q;
    good_d     = good_q;
    tcnt_d     = tcnt_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    if (bck_rise) begin
      tcnt_d = '0;
      if (bitcnt_q < FULL) begin
        shift_inc  = {shift_q[SAMPLE_BITS-2:0], data_s};
        bitcnt_inc = bitcnt_q + CW'(1);
      end
      shift_d  = shift_inc;
      bitcnt_d = bitcnt_inc;
      // LRCK change: the bit just taken was the LSB of the outgoing slot.
      if (lrck_s != lrck_prev_q) begin
        bitcnt_d = '0;
        if (!aligned_q) begin
          aligned_d = 1'b1;
        end else if (bitcnt_inc == FULL && !lrck_prev_q) begin
          held_d    = shift_inc;
          left_ok_d = 1'b1;
        end else if (bitcnt_inc == FULL && left_ok_q) begin
          left_d    = held_q;
          right_d   = shift_inc;
          valid_d   = 1'b1;
          left_ok_d = 1'b0;
          if (good_q != 2'd2) good_d = good_q + 2'd1;
        end else if (bitcnt_inc < FULL) begin
          err_d     = 1'b1;
          left_ok_d = 1'b0;
          good_d    = 2'd0;
        end
      end
    end else if (tcnt_q != TLAST) begin
      tcnt_d = tcnt_q + TW'(1);
      if (tcnt_q == TTRIG) begin
        err_d     = 1'b1;
        aligned_d = 1'b0;
        left_ok_d = 1'b0;
        good_d    = 2'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shift_q   <= '0;
      bitcnt_q  <= '0;
      held_q    <= '0;
      left_q    <= '0;
      right_q   <= '0;
      tcnt_q    <= '0;
      good_q    <= 2'd0;
      aligned_q <= 1'b0;
      left_ok_q <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      bitcnt_q  <= bitcnt_d;
      held_q    <= held_d;
      left_q    <= left_d;
      right_q   <= right_d;
      tcnt_q    <= tcnt_d;
      good_q    <= good_d;
      aligned_q <= aligned_d;
      left_ok_q <= left_ok_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

`ifdef I2S_RX_ERR_CNT_EN
  logic [7:0] errcnt_q;
  always_ff @(posedge clk) begin
    if (!reset_n) errcnt_q <= 8'd0;
    else if (err_d && errcnt_q != 8'hFF) errcnt_q <= errcnt_q + 8'd1;
  end
  assign err_count = errcnt_q;
`endif

  assign left         = left_q;
  assign right        = right_q;
  assign sample_valid = valid_q;
  assign frame_err    = err_q;
  assign locked       = (good_q == 2'd2);

endmodule

// File: tb/tb_i2s_rx_deser.sv
// tb/tb_i2s_rx_deser.sv - scoreboard bench for i2s_rx_deser with a slot-level reference model
module tb_i2s_rx_deser;
  localparam int SB = 16;

  logic        clk = 1'b0;
  logic        reset_n, i2s_bck, i2s_lrck, i2s_data;
  logic [15:0] left, right;
  logic        sample_valid, frame_err, locked;
`ifdef I2S_RX_ERR_CNT_EN
  logic [7:0]  err_count;
`endif

  always #5 clk = ~clk;

  i2s_rx_deser #(.SAMPLE_BITS(16), .SYNC_STAGES(2), .TIMEOUT_CYCLES(256)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .i2s_bck(i2s_bck),
    .i2s_lrck(i2s_lrck),
    .i2s_data(i2s_data),
    .left(left),
    .right(right),
    .sample_valid(sample_valid),
    .frame_err(frame_err),
`ifdef I2S_RX_ERR_CNT_EN
    .err_count(err_count),
`endif
    .locked(locked)
  );

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    bit          is_err;
    logic [15:0] l;
    logic [15:0] r;
    bit          lk;
  } exp_t;
  exp_t exp_q[$];

  bit          m_aligned, m_left_ok;
  int          m_good, m_errs;
  logic [15:0] m_held, m_left, m_right;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic model_reset();
    m_aligned = 0; m_left_ok = 0; m_good = 0; m_errs = 0;
    m_held = '0; m_left = '0; m_right = '0;
  endtask

  task automatic push_err();
    exp_t e;
    m_left_ok = 0;
    m_good = 0;
    m_errs++;
    e.is_err = 1; e.l = m_left; e.r = m_right; e.lk = 0;
    exp_q.push_back(e);
  endtask

  // Outcome of one slot ending, judged by its channel and length only.
  task automatic model_slot(input bit ch, input int n, input logic [31:0] val);
    exp_t e;
    logic [15:0] top;
    top = '0;
    if (n >= SB) top = 16'(val >> (n - SB));
    if (!m_aligned) begin
      m_aligned = 1;
    end else if (n < SB) begin
      push_err();
    end else if (ch == 1'b0) begin
      m_held = top;
      m_left_ok = 1;
    end else if (m_left_ok) begin
      m_left_ok = 0;
      m_good = (m_good < 2) ? m_good + 1 : 2;
      m_left = m_held;
      m_right = top;
      e.is_err = 0; e.l = m_left; e.r = m_right; e.lk = (m_good == 2);
      exp_q.push_back(e);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_left"}, 32'(left), 32'(0));
    check({tag, "_right"}, 32'(right), 32'(0));
    check({tag, "_valid"}, 32'(sample_valid), 32'(0));
    check({tag, "_err"}, 32'(frame_err), 32'(0));
    check({tag, "_locked"}, 32'(locked), 32'(0));
`ifdef I2S_RX_ERR_CNT_EN
    check({tag, "_err_count"}, 32'(err_count), 32'(0));
`endif
  endtask

  // One I2S slot, BCK = clk/8; LRCK already shows the next channel on the LSB.
  task automatic send_slot(input bit ch, input int n, input logic [31:0] val, input int rst_bit);
    for (int i = 0; i < n; i++) begin
      i2s_bck  = 1'b0;
      i2s_lrck = (i == n - 1) ? ~ch : ch;
      i2s_data = val[n-1-i];
      for (int k = 0; k < 4; k++) begin
        if (i == rst_bit && k == 0) reset_n = 1'b0;
        @(negedge clk);
        if (i == rst_bit && k == 0) begin
          check_zero("midslot_reset");
          reset_n = 1'b1;
          model_reset();
        end
      end
      if (i == n - 1) model_slot(ch, n, val);
      i2s_bck = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  function automatic logic [31:0] rval(input int n);
    logic [31:0] v;
    v = $urandom;
    if (n < 32) v = v & ((32'h1 << n) - 32'h1);
    return v;
  endfunction

  task automatic send_frame(input int nl, input logic [31:0] vl, input int nr, input logic [31:0] vr);
    send_slot(1'b0, nl, vl, -1);
    send_slot(1'b1, nr, vr, -1);
  endtask

  task automatic send_rand_frame();
    int nl, nr;
    nl = $urandom_range(16, 32);
    nr = $urandom_range(16, 32);
    send_frame(nl, rval(nl), nr, rval(nr));
  endtask

  task automatic stop_bck(input int cycles);
    int first;
    first = -1;
    i2s_bck = 1'b0;
    push_err();
    m_aligned = 0;
    for (int k = 1; k <= cycles; k++) begin
      @(negedge clk);
      if (frame_err && first < 0) first = k;
    end
    check("timeout_latency_in_window", 32'(first >= 250 && first <= 262), 32'(1));
    check("timeout_left_held", 32'(left), 32'(m_left));
    check("timeout_right_held", 32'(right), 32'(m_right));
    check("timeout_locked", 32'(locked), 32'(m_good == 2));
  endtask

  // Monitor: every DUT event must match the oldest expected event.
  always @(negedge clk) begin
    exp_t e;
    if (sample_valid || frame_err) begin
      check("valid_err_exclusive", 32'(sample_valid & frame_err), 32'(0));
      check("event_expected", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("event_is_err", 32'(frame_err), 32'(e.is_err));
        check("event_left", 32'(left), 32'(e.l));
        check("event_right", 32'(right), 32'(e.r));
        check("event_locked", 32'(locked), 32'(e.lk));
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; i2s_bck = 1'b0; i2s_lrck = 1'b0; i2s_data = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    check_zero("reset");
    reset_n = 1'b1;

    repeat (3) send_frame(16, 32'h0000_A5C3, 16, 32'h0000_3C5A);
    check("locked_after_3_frames", 32'(locked), 32'(m_good == 2));

    repeat (2) send_frame(32, 32'h1234_FFFF, 32, 32'h8001_0000);
    check("left_64fs", 32'(left), 32'h1234);
    check("right_64fs", 32'(right), 32'h8001);

    repeat (6) send_rand_frame();

    send_slot(1'b0, 16, rval(16), -1);
    send_slot(1'b1, 10, rval(10), -1);
    check("locked_after_short_slot", 32'(locked), 32'(m_good == 2));
    repeat (3) send_rand_frame();
    check("relocked_after_short", 32'(locked), 32'(m_good == 2));

    stop_bck(300);
    repeat (4) send_rand_frame();
    check("relocked_after_timeout", 32'(locked), 32'(m_good == 2));

    send_slot(1'b0, 24, rval(24), 5);
    send_slot(1'b1, 16, rval(16), -1);
    repeat (3) send_rand_frame();
    check("relocked_after_reset", 32'(locked), 32'(m_good == 2));

`ifdef I2S_RX_ERR_CNT_EN
    for (int k = 0; k < 260; k++) send_slot(1'(k % 2), 4, rval(4), -1);
    check("err_count_saturated", 32'(err_count), 32'((m_errs > 255) ? 255 : m_errs));
    check("err_count_is_255", 32'(err_count), 32'd255);
`endif

    repeat (20) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
